serial_frame_tx: RTL

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_tx_pkg.sv | 19 +
 rtl/tx_shift_reg.sv | 40 ++++
 rtl/serial_frame_tx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// default payload width and the bit-counter width helper.
package serial_frame_tx_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    // A single-bit payload still needs a one-bit counter.
    function automatic int cnt_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Payload shift register: synchronous reset, parallel load, right shift.
// Exposes only the bit currently due on the line.
module tx_shift_reg
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              lsb
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = sr_q >> 1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign lsb = sr_q[0];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W payload bits LSB first, stop bit.
// Falling-edge logic; all outputs come straight from flops.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              C,
    input  logic              RE,
    input  logic [DATA_W-1:0] D,
    input  logic              LOAD,
    output logic              TXD,
    output logic              BUSY,
    output logic              DONE
);

    localparam int               CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_lsb;

    tx_shift_reg #(
        .DATA_W(DATA_W)
    ) u_shift (
        .clk  (C),
        .rst  (RE),
        .load (sr_load),
        .shift(sr_shift),
        .d    (D),
        .lsb  (sr_lsb)
    );

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (LOAD) begin
                    sr_load = 1'b1;
                    state_d = START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d  = DATA;
                cnt_d    = '0;
                txd_d    = sr_lsb;
                busy_d   = 1'b1;
                sr_shift = 1'b1;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    txd_d    = sr_lsb;
                    sr_shift = 1'b1;
                end
            end
            STOP: begin
                cnt_d = '0;
                if (LOAD) begin
                    sr_load = 1'b1;
                    state_d = START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(negedge C) begin
        if (RE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign TXD  = txd_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
